// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: framer state encoding, line patterns, CRC-16 constants
// and the zero-insertion threshold.
package hdlc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
        FCS,
        END_FLAG,
        ABORT
    } txState_e;

    localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT  = 8'hFE;
    localparam logic [15:0] CRC16_POLY  = 16'h1021;
    localparam logic [15:0] CRC16_INIT  = 16'h0000;
    localparam logic [2:0]  STUFF_LIMIT = 3'd5;

    // Run length of consecutive ones after putting lineBit on the wire.
    function automatic logic [2:0] onesAfter(input logic [2:0] ones, input logic lineBit);
        return lineBit ? ones + 3'd1 : 3'd0;
    endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 (x^16+x^12+x^5+1): one bit per enabled cycle, frame bits fed in
// line order. Clear has priority over Enable.
module hdlc_tx_fcs
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Clear,
    input  logic        Enable,
    input  logic        DataBit,
    output logic [15:0] Crc
);

    logic feedback;

    assign feedback = DataBit ^ Crc[15];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Crc <= CRC16_INIT;
        end else if (Clear) begin
            Crc <= CRC16_INIT;
        end else if (Enable) begin
            Crc <= {Crc[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// Bit-level HDLC transmit framer: flags, zero insertion, CRC-16 FCS and abort
// sequence, one line bit per TxEN slot. DbgState exposes the FSM state.
module hdlc_tx_framer
    import hdlc_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxEN,
    input  logic       Tx_ValidFrame,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_Last,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_FCSDone,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Underrun,
    output logic [2:0] DbgState
);

    txState_e    state, nextState;
    logic [3:0]  bitCnt, nextBitCnt;
    logic [7:0]  shiftReg, nextShift;
    logic        lastReg, nextLast;
    logic [2:0]  onesCnt, nextOnes;
    logic        abortLatch, nextAbort;
    logic        nextTx;
    logic        nextFcsDone, nextDone, nextAborted, nextUnderrun;
    logic        crcClear, crcEnable, crcBit;
    logic [15:0] crc;
    logic        inFrame;

    hdlc_tx_fcs fcsGen (
        .Clk     (Clk),
        .Rst     (Rst),
        .Clear   (crcClear),
        .Enable  (crcEnable),
        .DataBit (crcBit),
        .Crc     (crc)
    );

    assign DbgState = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state           <= IDLE;
            bitCnt          <= 4'd0;
            shiftReg        <= 8'h00;
            lastReg         <= 1'b0;
            onesCnt         <= 3'd0;
            abortLatch      <= 1'b0;
            Tx              <= 1'b1;
            Tx_FCSDone      <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_Underrun     <= 1'b0;
        end else begin
            state           <= nextState;
            bitCnt          <= nextBitCnt;
            shiftReg        <= nextShift;
            lastReg         <= nextLast;
            onesCnt         <= nextOnes;
            abortLatch      <= nextAbort;
            Tx              <= nextTx;
            Tx_FCSDone      <= nextFcsDone;
            Tx_Done         <= nextDone;
            Tx_AbortedTrans <= nextAborted;
            Tx_Underrun     <= nextUnderrun;
        end
    end

    always_comb begin
        nextState    = state;
        nextBitCnt   = bitCnt;
        nextShift    = shiftReg;
        nextLast     = lastReg;
        nextOnes     = onesCnt;
        nextTx       = Tx;
        nextFcsDone  = 1'b0;
        nextDone     = 1'b0;
        nextAborted  = 1'b0;
        nextUnderrun = 1'b0;
        Tx_RdBuff    = 1'b0;
        crcClear     = 1'b0;
        crcEnable    = 1'b0;
        crcBit       = 1'b0;
        inFrame      = (state == START_FLAG) || (state == DATA) || (state == FCS);
        // An abort request outside the frame body is simply dropped.
        nextAbort    = inFrame && (abortLatch || Tx_AbortFrame);

        if (TxEN) begin
            if (inFrame && abortLatch) begin
                nextState  = ABORT;
                nextTx     = HDLC_ABORT[0];
                nextBitCnt = 4'd1;
                nextOnes   = 3'd0;
                nextAbort  = 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        nextTx = 1'b1;
                        if (Tx_ValidFrame && Tx_DataValid && !Rst) begin
                            Tx_RdBuff  = 1'b1;
                            nextShift  = Tx_Data;
                            nextLast   = Tx_Last;
                            nextBitCnt = 4'd0;
                            nextState  = START_FLAG;
                        end
                    end
                    START_FLAG: begin
                        nextTx   = HDLC_FLAG[bitCnt[2:0]];
                        crcClear = 1'b1;
                        if (bitCnt == 4'd7) begin
                            nextState  = DATA;
                            nextBitCnt = 4'd0;
                            nextOnes   = 3'd0;
                        end else begin
                            nextBitCnt = bitCnt + 4'd1;
                        end
                    end
                    DATA: begin
                        if (onesCnt == STUFF_LIMIT) begin
                            nextTx   = 1'b0;
                            nextOnes = 3'd0;
                        end else if (!bitCnt[3]) begin
                            nextTx     = shiftReg[bitCnt[2:0]];
                            crcEnable  = 1'b1;
                            crcBit     = shiftReg[bitCnt[2:0]];
                            nextOnes   = onesAfter(onesCnt, shiftReg[bitCnt[2:0]]);
                            nextBitCnt = bitCnt + 4'd1;
                        end else if (lastReg) begin
                            // Byte boundary slot: it already carries the first FCS bit.
                            nextState  = FCS;
                            nextTx     = crc[0];
                            nextOnes   = onesAfter(onesCnt, crc[0]);
                            nextBitCnt = 4'd1;
                        end else if (Tx_DataValid) begin
                            Tx_RdBuff  = 1'b1;
                            nextShift  = Tx_Data;
                            nextLast   = Tx_Last;
                            nextTx     = Tx_Data[0];
                            crcEnable  = 1'b1;
                            crcBit     = Tx_Data[0];
                            nextOnes   = onesAfter(onesCnt, Tx_Data[0]);
                            nextBitCnt = 4'd1;
                        end else begin
                            nextUnderrun = 1'b1;
                            nextState    = ABORT;
                            nextTx       = HDLC_ABORT[0];
                            nextBitCnt   = 4'd1;
                            nextOnes     = 3'd0;
                            nextAbort    = 1'b0;
                        end
                    end
                    FCS: begin
                        if (onesCnt == STUFF_LIMIT) begin
                            nextTx   = 1'b0;
                            nextOnes = 3'd0;
                        end else begin
                            nextTx   = crc[bitCnt];
                            nextOnes = onesAfter(onesCnt, crc[bitCnt]);
                            if (bitCnt == 4'd15) begin
                                nextFcsDone = 1'b1;
                                nextState   = END_FLAG;
                                nextBitCnt  = 4'd0;
                                nextOnes    = 3'd0;
                            end else begin
                                nextBitCnt = bitCnt + 4'd1;
                            end
                        end
                    end
                    END_FLAG: begin
                        nextTx = HDLC_FLAG[bitCnt[2:0]];
                        if (bitCnt == 4'd7) begin
                            nextDone   = 1'b1;
                            nextState  = IDLE;
                            nextBitCnt = 4'd0;
                        end else begin
                            nextBitCnt = bitCnt + 4'd1;
                        end
                    end
                    ABORT: begin
                        nextTx = HDLC_ABORT[bitCnt[2:0]];
                        if (bitCnt == 4'd7) begin
                            nextAborted = 1'b1;
                            nextState   = IDLE;
                            nextBitCnt  = 4'd0;
                        end else begin
                            nextBitCnt = bitCnt + 4'd1;
                        end
                    end
                    default: nextState = IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: TxEN every second cycle, a byte queue as TX
// buffer, captured line bits compared against hand-derived and modelled streams.
module tb_hdlc_tx_framer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       TxEN = 1'b0;
    logic       Tx_ValidFrame = 1'b0;
    logic       Tx_AbortFrame = 1'b0;
    logic [7:0] Tx_Data = 8'h00;
    logic       Tx_DataValid = 1'b0;
    logic       Tx_Last = 1'b0;
    logic       Tx_RdBuff, Tx, Tx_FCSDone, Tx_Done, Tx_AbortedTrans, Tx_Underrun;
    logic [2:0] DbgState;

    hdlc_tx_framer dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .TxEN            (TxEN),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_Data         (Tx_Data),
        .Tx_DataValid    (Tx_DataValid),
        .Tx_Last         (Tx_Last),
        .Tx_RdBuff       (Tx_RdBuff),
        .Tx              (Tx),
        .Tx_FCSDone      (Tx_FCSDone),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans),
        .Tx_Underrun     (Tx_Underrun),
        .DbgState        (DbgState)
    );

    // ---------------- clock / watchdog ----------------
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] bufQ[$];
    logic [7:0] frameBytes[$];
    logic [0:0] exp_q[$];
    logic [0:0] gotQ[$];
    bit   lastOnFinal;
    logic sRd, sTx, sFcs, sDone, sAb, sUr;
    int   pops, fcsSlot, doneSlot, abSlot, urSlot, injSlot, stuffCount;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic update_buf();
        Tx_DataValid = (bufQ.size() > 0);
        Tx_Data      = (bufQ.size() > 0) ? bufQ[0] : 8'h00;
        Tx_Last      = lastOnFinal && (bufQ.size() == 1);
    endtask

    // One TxEN slot: RdBuff sampled before the edge, outputs 1 time unit after it.
    task automatic drive_slot();
        @(negedge Clk);
        update_buf();
        TxEN = 1'b1;
        #1 sRd = Tx_RdBuff;
        @(posedge Clk);
        #1 TxEN = 1'b0;
        sTx   = Tx;
        sFcs  = Tx_FCSDone;
        sDone = Tx_Done;
        sAb   = Tx_AbortedTrans;
        sUr   = Tx_Underrun;
        if (sRd && bufQ.size() > 0) void'(bufQ.pop_front());
        update_buf();
    endtask

    task automatic gap_cycle(input bit injectAbort);
        @(negedge Clk);
        Tx_AbortFrame = injectAbort;
        @(posedge Clk);
        #1 Tx_AbortFrame = 1'b0;
    endtask

    task automatic run_frame(input int injectPops, input int injectDelay, input int maxSlots);
        int cnt;
        bit fin;
        bit inj;
        gotQ.delete();
        pops = 0; fcsSlot = -1; doneSlot = -1; abSlot = -1; urSlot = -1; injSlot = -1;
        cnt = 0;
        fin = 1'b0;
        for (int s = 0; s < maxSlots && !fin; s++) begin
            drive_slot();
            gotQ.push_back(sTx);
            if (sRd) pops++;
            if (sFcs) fcsSlot = s;
            if (sUr) urSlot = s;
            if (sDone) begin doneSlot = s; fin = 1'b1; end
            if (sAb) begin abSlot = s; fin = 1'b1; end
            inj = 1'b0;
            if (injectPops > 0 && injSlot < 0 && pops == injectPops) begin
                if (cnt == injectDelay) begin
                    inj = 1'b1;
                    injSlot = s;
                end else begin
                    cnt++;
                end
            end
            gap_cycle(inj);
        end
        check("frame_end_reached", {31'd0, fin}, 32'd1);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] crc16_ref();
        logic [15:0] c;
        logic fb;
        logic [7:0] b;
        c = 16'h0000;
        foreach (frameBytes[k]) begin
            b = frameBytes[k];
            for (int i = 0; i < 8; i++) begin
                fb = b[i] ^ c[15];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) exp_q.push_back(v[i]);
    endtask

    // Expected line: accept-slot idle 1, flag, stuffed data+FCS, flag.
    task automatic build_exp();
        logic [0:0] body[$];
        logic [15:0] c;
        logic [7:0] b;
        int ones;
        exp_q.delete();
        stuffCount = 0;
        exp_q.push_back(1'b1);
        push_byte(8'h7E);
        foreach (frameBytes[k]) begin
            b = frameBytes[k];
            for (int i = 0; i < 8; i++) body.push_back(b[i]);
        end
        c = crc16_ref();
        for (int i = 0; i < 16; i++) body.push_back(c[i]);
        ones = 0;
        foreach (body[i]) begin
            exp_q.push_back(body[i]);
            ones = body[i] ? ones + 1 : 0;
            if (ones == 5 && i != body.size() - 1) begin
                exp_q.push_back(1'b0);
                stuffCount++;
                ones = 0;
            end
        end
        push_byte(8'h7E);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, gotQ.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < gotQ.size(); i++)
            check($sformatf("%s_bit%0d", name, i), {31'd0, gotQ[i]}, {31'd0, exp_q[i]});
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [8:0] ffPat;
        logic [7:0] abPat;
        ffPat = 9'b111_0_11111;   // line order bit0 first: 1,1,1,1,1,0,1,1,1
        abPat = 8'hFE;            // line order: 0 then seven 1s

        // Reset behaviour, with a request and a byte pending during reset.
        bufQ = '{8'h33};
        lastOnFinal = 1'b1;
        Tx_ValidFrame = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_slot();
            check("rst_rdbuff", {31'd0, sRd}, 32'd0);
            check("rst_tx", {31'd0, sTx}, 32'd1);
            check("rst_pulses", {28'd0, sFcs, sDone, sAb, sUr}, 32'd0);
            gap_cycle(1'b0);
        end
        check("rst_state", {29'd0, DbgState}, 32'd0);
        Tx_ValidFrame = 1'b0;
        bufQ.delete();
        @(negedge Clk) Rst = 1'b0;
        drive_slot();
        check("idle_tx", {31'd0, sTx}, 32'd1);
        gap_cycle(1'b0);

        // One-byte frame 00: FCS of a zero byte from a zero CRC is all zeros.
        frameBytes = '{8'h00};
        bufQ = '{8'h00};
        Tx_ValidFrame = 1'b1;
        build_exp();
        run_frame(0, 0, 120);
        compare_stream("f00");
        for (int i = 17; i < 33 && i < gotQ.size(); i++)
            check($sformatf("f00_fcs%0d", i - 17), {31'd0, gotQ[i]}, 32'd0);
        check("f00_fcsdone_slot", fcsSlot, 32);
        check("f00_done_slot", doneSlot, 40);
        check("f00_pops", pops, 1);

        // Back-to-back two-byte frame FF,01 with ValidFrame held.
        frameBytes = '{8'hFF, 8'h01};
        bufQ = '{8'hFF, 8'h01};
        build_exp();
        run_frame(0, 0, 120);
        compare_stream("fff01");
        for (int i = 0; i < 9 && 9 + i < gotQ.size(); i++)
            check($sformatf("fff01_first%0d", i), {31'd0, gotQ[9 + i]}, {31'd0, ffPat[i]});
        check("fff01_len_total", gotQ.size(), 1 + 8 + 16 + 16 + 8 + stuffCount);
        check("fff01_pops", pops, 2);
        check("fff01_fcsdone_slot", fcsSlot, gotQ.size() - 9);
        check("fff01_done_slot", doneSlot, gotQ.size() - 1);

        // Abort during the second data byte.
        frameBytes = '{8'hA5, 8'h3C, 8'h81};
        bufQ = '{8'hA5, 8'h3C, 8'h81};
        build_exp();
        run_frame(2, 3, 120);
        check("abt_len", gotQ.size(), injSlot + 9);
        for (int i = 1; i <= injSlot && i < gotQ.size(); i++)
            check($sformatf("abt_prefix%0d", i), {31'd0, gotQ[i]}, {31'd0, exp_q[i]});
        for (int i = 0; i < 8 && injSlot + 1 + i < gotQ.size(); i++)
            check($sformatf("abt_pat%0d", i), {31'd0, gotQ[injSlot + 1 + i]}, {31'd0, abPat[i]});
        check("abt_aborted_slot", abSlot, injSlot + 8);
        check("abt_no_fcsdone", fcsSlot, -1);
        check("abt_no_done", doneSlot, -1);
        check("abt_pops", pops, 2);
        bufQ.delete();

        // Underrun: only one byte of a longer frame is available.
        lastOnFinal = 1'b0;
        bufQ = '{8'h0F};
        exp_q.delete();
        exp_q.push_back(1'b1);
        push_byte(8'h7E);
        push_byte(8'h0F);
        push_byte(8'hFE);
        run_frame(0, 0, 120);
        Tx_ValidFrame = 1'b0;
        compare_stream("urn");
        check("urn_underrun_slot", urSlot, 17);
        check("urn_aborted_slot", abSlot, 24);
        check("urn_no_done", doneSlot, -1);
        check("urn_no_fcsdone", fcsSlot, -1);
        check("urn_pops", pops, 1);
        drive_slot();
        check("urn_idle_tx", {31'd0, sTx}, 32'd1);
        check("urn_idle_state", {29'd0, DbgState}, 32'd0);
        gap_cycle(1'b0);

        // Reset in the middle of the FCS, then a clean frame.
        lastOnFinal = 1'b1;
        bufQ = '{8'h55};
        Tx_ValidFrame = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_slot();
            gap_cycle(1'b0);
        end
        check("mid_state_fcs", {29'd0, DbgState}, 32'd3);
        @(negedge Clk);
        #2 Rst = 1'b1;
        #1;
        check("mid_rst_tx", {31'd0, Tx}, 32'd1);
        check("mid_rst_pulses", {28'd0, Tx_FCSDone, Tx_Done, Tx_AbortedTrans, Tx_Underrun}, 32'd0);
        bufQ.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk) Rst = 1'b0;
        frameBytes = '{8'hA5};
        bufQ = '{8'hA5};
        build_exp();
        run_frame(0, 0, 120);
        Tx_ValidFrame = 1'b0;
        compare_stream("post_rst");
        check("post_rst_done_slot", doneSlot, gotQ.size() - 1);
        check("post_rst_pops", pops, 1);

        drive_slot();
        check("final_idle_tx", {31'd0, sTx}, 32'd1);
        gap_cycle(1'b0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
